bp_update_queue: RTL

In-order tracking queue for conditional branches between fetch and execute; it is the write-side partner of the 2-bit-counter branch predictor table.
- Fetch pushes each predicted branch: predictor index plus predicted direction.
- Execute resolves branches oldest-first with the actual outcome.
- The block emits one predictor update write per resolved branch.
- On a wrong prediction it raises a one-cycle mispredict and discards all younger in-flight entries.

---
 rtl/bp_update_queue.sv | 113 +++++++++++
 1 files changed

// File: rtl/bp_update_queue.sv
// In-order branch tracking queue: emits predictor update writes and mispredict pulses.
// Optional saturating statistics counters are enabled by defining BPQ_STATS_EN.
module bp_update_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [IDX_W-1:0]           push_idx,
    input  logic                       push_pred,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic                       flush,
    output logic                       upd_we,
    output logic [IDX_W-1:0]           upd_addr,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       res_err
`ifdef BPQ_STATS_EN
    ,
    output logic [15:0]                stat_resolved,
    output logic [15:0]                stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [IDX_W:0]     head;
    logic               do_push;
    logic               do_res;
    logic               mis;

    always_comb begin
        head       = mem[rd_ptr];
        push_ready = (count != CNT_W'(DEPTH));
        do_push    = push_valid & push_ready;
        do_res     = res_valid & (count != '0);
        mis        = do_res & (res_taken != head[0]);
    end

    // A push is only stored when it survives: no flush and no mispredict this cycle.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !mis) begin
            mem[wr_ptr] <= {push_idx, push_pred};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            upd_we     <= 1'b0;
            upd_addr   <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            upd_we     <= 1'b0;
            mispredict <= 1'b0;
            if (res_valid && count == '0) begin
                res_err <= 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (do_res) begin
                    upd_we     <= 1'b1;
                    upd_addr   <= head[IDX_W:1];
                    upd_taken  <= res_taken;
                    mispredict <= mis;
                end
                if (mis) begin
                    rd_ptr <= wr_ptr;
                    count  <= '0;
                end else begin
                    if (do_push) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (do_res) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    count <= count + CNT_W'(do_push) - CNT_W'(do_res);
                end
            end
        end
    end

`ifdef BPQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else if (!flush) begin
            if (do_res && stat_resolved != '1) begin
                stat_resolved <= stat_resolved + 16'd1;
            end
            if (mis && stat_mispred != '1) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`endif

endmodule
